cdecv_clock_step_receiver: RTL
==============================

Name: cdecv_clock_step_receiver

Overview:
Sits on the cdecv side of the monitor-driven clock line, the receiving end of the monitor's software-written clock output bit. Synchronizes and edge-detects the monitor clock level and converts each rising edge into exactly one single-cycle clock-enable pulse for the cdecv core. Also provides a free-running divider mode and step/drop counters. Counters are readable, and clearable through a small Avalon-MM slave port.

Parameters:
SYNC_STAGES, 2, flops in the input synchronizer chain (minimum 2)
DIV_W, 16, width of the free-run divider counter and div_value
HOLDOFF_CYCLES, 4, lockout cycles after each pulse; triggers in lockout are dropped (minimum 1)

Ports:
clk  in  1  single system clock
reset  in  1  synchronous reset, active-high
monitor_clk_in  in  1  level from the monitor clock output bit
run_en  in  1  1 = free-run divider mode, 0 = manual step mode
div_value  in  DIV_W  free-run period minus 1
cpu_halt  in  1  core halted; new triggers suppressed
clk_en_out  out  1  single-cycle clock enable to the cdecv core
step_count  out  32  number of pulses issued
address  in  2  register select
chipselect  in  1  slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  write data (value ignored; any write clears)
readdata  out  32  registered read data

Behaviour:
- Reset is synchronous, active-high, and takes effect at the next clk edge.
- Reset values: all synchronizer flops 0, prev level 0, state IDLE, clk_en_out 0, step_count 0, drop_count 0, divider 0, readdata 0.
- Reset asserted mid-PULSE or mid-HOLDOFF aborts the operation. No pulse is emitted in the cycle after reset.
- Sync: monitor_clk_in passes through SYNC_STAGES flops to give sync_level. rise = sync_level & ~prev_level.
- Manual trigger = rise & ~run_en. A rise is only detected SYNC_STAGES+1 cycles after the input toggles.
- Divider: counts 0..div_value only while run_en=1; otherwise held at 0.
  - div_term = run_en & (div == div_value); div returns to 0 on div_term.
  - div_value=0 makes every cycle a term, so the rate is limited by holdoff.
- Run-mode trigger = div_term. Monitor edges are ignored in run mode and are not counted as drops.
- FSM states:
  - IDLE: on trigger & ~cpu_halt, go to PULSE. On trigger & cpu_halt, stay in IDLE and drop_count++.
  - PULSE: clk_en_out=1 for exactly this one cycle; step_count++; go to HOLDOFF with hcnt=HOLDOFF_CYCLES-1.
  - HOLDOFF: any trigger increments drop_count. Decrement hcnt; go to IDLE when hcnt==0.
- clk_en_out is asserted only in PULSE and is registered (state-decoded from a flop).
- Latency from the rise being detected to clk_en_out is 1 cycle.
- Minimum spacing between pulses is HOLDOFF_CYCLES+1 cycles.
- cpu_halt asserting during PULSE does not truncate the pulse.
- step_count wraps 0xFFFFFFFF to 0. drop_count is 8-bit and saturates at 0xFF.
- Register map:
  - addr0 = {30'b0, run_en, sync_level}
  - addr1 = step_count
  - addr2 = {24'b0, drop_count}
  - addr3 = {30'b0, state} with IDLE=0, PULSE=1, HOLDOFF=2
- Read: on chipselect & ~read_n, readdata is loaded next cycle (1-cycle latency). Otherwise readdata is 0 next cycle.
- Write: chipselect & ~write_n at addr1 clears step_count; at addr2 clears drop_count. Writes to addr0 and addr3 are ignored.
- Clear coincident with an increment: the result is 1, so the new event is kept.
- Simultaneous read and write of the same counter: the read returns the pre-clear value.

Test Plan:
- Reset, then toggle monitor_clk_in 0->1 with run_en=0, cpu_halt=0, SYNC_STAGES=2 -> clk_en_out high exactly 1 cycle, 4 cycles after the toggle edge; step_count=1.
- Two rises 2 cycles apart (HOLDOFF_CYCLES=4) -> one pulse; drop_count=1; second pulse only after a rise arriving after HOLDOFF ends.
- run_en=1, div_value=9 for 100 cycles -> pulses every 10 cycles, step_count=10 (±1 on window alignment); monitor toggles leave drop_count unchanged.
- cpu_halt=1 and 3 manual rises -> no clk_en_out; drop_count=3. Deassert halt, one rise -> one pulse.
- Preload step_count to 0xFFFFFFFF via pulses or force, one more pulse -> step_count=0. Write addr1 in the same cycle as a PULSE -> step_count=1.
- Assert reset during HOLDOFF -> next cycle state=0, counters 0, clk_en_out 0. Read addr3 -> readdata=0 one cycle after the read strobe.

Source files
------------

// File: rtl/cdecv_clock_step_receiver.sv
// Receiver for the monitor-driven clock line. Each synchronized rising edge of the
// monitor clock bit (or each divider terminal count in free-run mode) becomes one
// single-cycle clock enable for the cdecv core, followed by a lockout window.
// Step and drop counters are visible and clearable over a small Avalon-MM slave.
module cdecv_clock_step_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DIV_W          = 16,
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             monitor_clk_in,
    input  logic             run_en,
    input  logic [DIV_W-1:0] div_value,
    input  logic             cpu_halt,
    output logic             clk_en_out,
    output logic [31:0]      step_count,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata
);

    localparam int unsigned HcntW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HcntW-1:0] HcntLoad = HcntW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPulse   = 2'd1,
        StHoldoff = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [HcntW-1:0]       hcnt_q, hcnt_d;
    logic [31:0]            step_q, step_d;
    logic [7:0]             drop_q, drop_d;
    logic [31:0]            readdata_q, readdata_d;

    logic sync_level, rise, div_term, trigger;
    logic step_inc, drop_inc;
    logic bus_rd, bus_wr, clr_step, clr_drop;

    // Write data is irrelevant: any write to a counter address clears it.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign rise       = sync_level & ~prev_q;
    assign div_term   = run_en & (div_q == div_value);
    // Monitor edges are ignored entirely in free-run mode.
    assign trigger    = run_en ? div_term : rise;

    assign bus_rd   = chipselect & ~read_n;
    assign bus_wr   = chipselect & ~write_n;
    assign clr_step = bus_wr & (address == 2'd1);
    assign clr_drop = bus_wr & (address == 2'd2);

    // Synchronizer chain, edge-detect history and free-run divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            div_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], monitor_clk_in};
            prev_q <= sync_level;
            div_q  <= div_d;
        end
    end

    // Divider counts 0..div_value while in run mode, parked at 0 otherwise.
    always_comb begin
        div_d = '0;
        if (run_en && !div_term) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // FSM state register and holdoff counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            StIdle: begin
                if (trigger && !cpu_halt) begin
                    state_d = StPulse;
                end
            end
            StPulse: begin
                state_d = StHoldoff;
                hcnt_d  = HcntLoad;
            end
            StHoldoff: begin
                if (hcnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hcnt_d = hcnt_q - HcntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: enable decoded straight from the state flop; drop/step events.
    always_comb begin
        clk_en_out = (state_q == StPulse);
        step_inc   = (state_q == StPulse);
        drop_inc   = trigger & ((state_q == StHoldoff) | ((state_q == StIdle) & cpu_halt));
    end

    // Counter next values: a clear coincident with an event leaves a count of 1.
    always_comb begin
        step_d = step_q + {31'b0, step_inc};
        if (clr_step) begin
            step_d = {31'b0, step_inc};
        end
        drop_d = drop_q;
        if (drop_inc && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        if (clr_drop) begin
            drop_d = {7'b0, drop_inc};
        end
    end

    // Read mux uses pre-update values, so a read racing a clear sees the old count.
    always_comb begin
        readdata_d = '0;
        if (bus_rd) begin
            unique case (address)
                2'd0:    readdata_d = {30'b0, run_en, sync_level};
                2'd1:    readdata_d = step_q;
                2'd2:    readdata_d = {24'b0, drop_q};
                default: readdata_d = {30'b0, state_q};
            endcase
        end
    end

    // Counter and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q     <= '0;
            drop_q     <= '0;
            readdata_q <= '0;
        end else begin
            step_q     <= step_d;
            drop_q     <= drop_d;
            readdata_q <= readdata_d;
        end
    end

    assign step_count = step_q;
    assign readdata   = readdata_q;

endmodule
